// File: rtl/dr_phase_sequencer_if.sv
// Command/response bus between a requester and dr_phase_sequencer.
// With DR_SEQ_ILLEGAL_FLAG_EN defined the response also carries rsp_illegal.
interface dr_phase_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ph0;
    logic       cmd_ph1;
    logic       cmd_rd;
    logic       cmd_ld;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_c;
    logic [1:0] rsp_m;
    logic       rsp_timeout;
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
    logic       rsp_illegal;

    modport master (
        output cmd_valid, cmd_ph0, cmd_ph1, cmd_rd, cmd_ld, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_c, rsp_m, rsp_timeout, rsp_illegal
    );
    modport slave (
        input  cmd_valid, cmd_ph0, cmd_ph1, cmd_rd, cmd_ld, rsp_ready,
        output cmd_ready, rsp_valid, rsp_c, rsp_m, rsp_timeout, rsp_illegal
    );
`else
    modport master (
        output cmd_valid, cmd_ph0, cmd_ph1, cmd_rd, cmd_ld, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_c, rsp_m, rsp_timeout
    );
    modport slave (
        input  cmd_valid, cmd_ph0, cmd_ph1, cmd_rd, cmd_ld, rsp_ready,
        output cmd_ready, rsp_valid, rsp_c, rsp_m, rsp_timeout
    );
`endif
endinterface

// File: rtl/dr_phase_sequencer.sv
// Steps a dual-rail controller: drives one DATA wavefront, samples R_c/R_m, returns to NULL.
// Optional DR_SEQ_ILLEGAL_FLAG_EN adds a sticky rsp_illegal flag for 11 codes.
module dr_phase_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NULL_TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dr_phase_sequencer_if.slave  bus,
    output logic                 PH0_t,
    output logic                 PH0_f,
    output logic                 PH1_t,
    output logic                 PH1_f,
    output logic                 Rd_t,
    output logic                 Rd_f,
    output logic                 Ld_t,
    output logic                 Ld_f,
    input  logic                 R_c_t,
    input  logic                 R_c_f,
    input  logic                 R_m_t,
    input  logic                 R_m_f
);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > NULL_TIMEOUT) ? SETTLE_CYCLES : NULL_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_NULLW, ST_RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [7:0]       rails_q, rails_d;
    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       sync_d [SYNC_STAGES];
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_c_q, rsp_c_d;
    logic [1:0]       rsp_m_q, rsp_m_d;
    logic             rsp_to_q, rsp_to_d;
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
    logic             illegal_q, illegal_d;
`endif

    logic       ready_c;
    logic       handshake;
    logic       settle_done;
    logic       outs_null;
    logic       null_expired;
    logic [1:0] rc_s;
    logic [1:0] rm_s;

    // Dual-rail DATA encoding of {ph0, ph1, rd, ld}
    function automatic logic [7:0] encode(input logic [3:0] c);
        return {c[3], ~c[3], c[2], ~c[2], c[1], ~c[1], c[0], ~c[0]};
    endfunction

    assign rc_s         = sync_q[SYNC_STAGES-1][3:2];
    assign rm_s         = sync_q[SYNC_STAGES-1][1:0];
    assign ready_c      = rst_n && (state_q == ST_IDLE);
    assign handshake    = bus.cmd_valid && ready_c;
    assign settle_done  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign outs_null    = (rc_s == 2'b00) && (rm_s == 2'b00);
    assign null_expired = (cnt_q == CNT_W'(NULL_TIMEOUT - 1));

    // Synchronizer chain on the four asynchronous controller rails
    always_comb begin
        sync_d[0] = {R_c_t, R_c_f, R_m_t, R_m_f};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (handshake)                  state_d = ST_DATA;
            ST_DATA:  if (settle_done)                state_d = ST_NULLW;
            ST_NULLW: if (outs_null || null_expired)  state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready)              state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; the counter defaults to zero so every state entry clears it
    always_comb begin
        cnt_d     = '0;
        cmd_d     = cmd_q;
        rsp_c_d   = rsp_c_q;
        rsp_m_d   = rsp_m_q;
        rsp_to_d  = rsp_to_q;
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    cmd_d = {bus.cmd_ph0, bus.cmd_ph1, bus.cmd_rd, bus.cmd_ld};
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (settle_done) begin
                    rsp_c_d = rc_s;
                    rsp_m_d = rm_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_NULLW: begin
                if (outs_null)         rsp_to_d = 1'b0;
                else if (null_expired) rsp_to_d = 1'b1;
                else                   cnt_d    = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
        if (((state_q == ST_DATA) || (state_q == ST_NULLW)) &&
            ((rc_s == 2'b11) || (rm_s == 2'b11)))
            illegal_d = 1'b1;
        if ((state_q == ST_NULLW) && (state_d == ST_RESP) &&
            ((rsp_c_q == 2'b11) || (rsp_m_q == 2'b11)))
            illegal_d = 1'b1;
`endif
        rails_d     = (state_d == ST_DATA) ? encode(cmd_d) : 8'h00;
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cmd_q       <= '0;
            rails_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_m_q     <= '0;
            rsp_to_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            rails_q     <= rails_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_m_q     <= rsp_m_d;
            rsp_to_q    <= rsp_to_d;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign {PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f} = rails_q;
    assign bus.cmd_ready   = ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_c       = rsp_c_q;
    assign bus.rsp_m       = rsp_m_q;
    assign bus.rsp_timeout = rsp_to_q;
`ifdef DR_SEQ_ILLEGAL_FLAG_EN
    assign bus.rsp_illegal = illegal_q;
`endif

endmodule
